// File: rtl/back_icon_rr_controller_pkg.sv
// Shared datatypes for the interconnect round-robin controller and its channel FIFOs.
package pkg_dtypes;

  localparam int unsigned EUIDX_W       = 4;
  localparam int unsigned REGIDX_W      = 4;
  localparam int unsigned NUM_RECEIVERS = 8;

  typedef struct packed {
    logic [EUIDX_W-1:0]  euidx;
    logic [REGIDX_W-1:0] regidx;
  } type_exec_unit_addr;

  typedef logic [NUM_RECEIVERS-1:0] type_icon_receivers_list;

  typedef struct packed {
    type_exec_unit_addr      src_addr;
    type_icon_receivers_list receiver_list;
  } type_icon_instr;

  function automatic logic list_covered(input type_icon_receivers_list have,
                                        input type_icon_receivers_list need);
    return (have & need) == need;
  endfunction

endpackage

// File: rtl/back_icon_rr_controller_chan_fifo.sv
// Per-channel instruction queue: registered head, no push/pop bypass.
module back_icon_chan_fifo
  import pkg_dtypes::*;
#(
  parameter int unsigned LOG2_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  type_icon_instr push_data_i,
  input  logic           push_i,
  input  logic           pop_i,
  output type_icon_instr head_o,
  output logic           head_valid_o,
  output logic           full_o,
  output logic           empty_o
);

  localparam int unsigned DEPTH = 2 ** LOG2_DEPTH;

  logic [LOG2_DEPTH:0] wr_ptr_q, wr_ptr_d;
  logic [LOG2_DEPTH:0] rd_ptr_q, rd_ptr_d;
  type_icon_instr      mem_q [DEPTH];
  logic                push_en, pop_en;

  always_comb begin
    empty_o      = (wr_ptr_q == rd_ptr_q);
    full_o       = (wr_ptr_q[LOG2_DEPTH] != rd_ptr_q[LOG2_DEPTH]) &&
                   (wr_ptr_q[LOG2_DEPTH-1:0] == rd_ptr_q[LOG2_DEPTH-1:0]);
    push_en      = push_i & ~full_o;
    pop_en       = pop_i & ~empty_o;
    wr_ptr_d     = push_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d     = pop_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    head_o       = mem_q[rd_ptr_q[LOG2_DEPTH-1:0]];
    head_valid_o = ~empty_o;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q[LOG2_DEPTH-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/back_icon_rr_controller.sv
// Round-robin interconnect controller: per-channel queues, euidx source arbitration,
// receiver granting and retire tracking. Optional stall watchdog under ICON_WATCHDOG_EN.
module back_icon_rr_controller
  import pkg_dtypes::*;
#(
  parameter int unsigned NUM_ICON_CHANNELS = 4,
  parameter int unsigned LOG2_QUEUE_LENGTH = 4,
  parameter int unsigned WATCHDOG_CYCLES   = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  type_icon_instr                icon_instr_dispatch_i       [NUM_ICON_CHANNELS],
  input  logic [NUM_ICON_CHANNELS-1:0]  icon_instr_dispatch_valid_i,
  output logic [NUM_ICON_CHANNELS-1:0]  icon_instr_dispatch_ready_o,
  output type_exec_unit_addr            src_addrs_o                 [NUM_ICON_CHANNELS],
  output type_icon_receivers_list       receiver_lists_o            [NUM_ICON_CHANNELS],
  output logic [NUM_ICON_CHANNELS-1:0]  channel_active_o,
  output logic [NUM_ICON_CHANNELS-1:0]  tx_req_valid_o,
  input  type_icon_receivers_list       success_lists_i             [NUM_ICON_CHANNELS],
  output logic [NUM_ICON_CHANNELS-1:0]  instr_retire_o,
  output logic [NUM_ICON_CHANNELS-1:0]  timeout_o
);

  localparam int unsigned N     = NUM_ICON_CHANNELS;
  localparam int unsigned PTR_W = $clog2(N);

  type_icon_instr          head       [N];
  logic [N-1:0]            head_valid, chan_full, chan_empty, pop;
  type_icon_receivers_list latch_q    [N];
  type_icon_receivers_list latch_d    [N];
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;

  for (genvar g = 0; g < N; g++) begin : g_chan
    back_icon_chan_fifo #(.LOG2_DEPTH(LOG2_QUEUE_LENGTH)) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .push_data_i  (icon_instr_dispatch_i[g]),
      .push_i       (icon_instr_dispatch_valid_i[g]),
      .pop_i        (pop[g]),
      .head_o       (head[g]),
      .head_valid_o (head_valid[g]),
      .full_o       (chan_full[g]),
      .empty_o      (chan_empty[g])
    );
  end

  assign icon_instr_dispatch_ready_o = ~chan_full;
  assign channel_active_o            = ~chan_empty;
  assign pop                         = instr_retire_o | timeout_o;

  // Walk channels in priority order; grants accumulate so lower-priority
  // channels only see receivers nobody above them has claimed.
  always_comb begin
    type_icon_receivers_list granted;
    int unsigned             sum;
    logic [PTR_W-1:0]        ch, hp;
    logic                    blocked;
    granted        = '0;
    sum            = 0;
    ch             = '0;
    hp             = '0;
    blocked        = 1'b0;
    tx_req_valid_o = '0;
    for (int unsigned k = 0; k < N; k++) receiver_lists_o[k] = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum = int'(rr_ptr_q) + k;
      if (sum >= N) sum = sum - N;
      ch      = PTR_W'(sum);
      blocked = 1'b0;
      for (int unsigned j = 0; j < k; j++) begin
        sum = int'(rr_ptr_q) + j;
        if (sum >= N) sum = sum - N;
        hp = PTR_W'(sum);
        if (head_valid[hp] && (head[hp].src_addr.euidx == head[ch].src_addr.euidx))
          blocked = 1'b1;
      end
      tx_req_valid_o[ch] = head_valid[ch] & ~blocked;
      if (tx_req_valid_o[ch])
        receiver_lists_o[ch] = head[ch].receiver_list & ~latch_q[ch] & ~granted;
      granted = granted | receiver_lists_o[ch];
    end
  end

  always_comb begin
    instr_retire_o = '0;
    for (int unsigned c = 0; c < N; c++) begin
      src_addrs_o[c]    = head_valid[c] ? head[c].src_addr : '0;
      instr_retire_o[c] = head_valid[c] &
                          list_covered(latch_q[c] | (success_lists_i[c] & receiver_lists_o[c]),
                                       head[c].receiver_list);
      latch_d[c]        = pop[c] ? '0 : (latch_q[c] | (success_lists_i[c] & receiver_lists_o[c]));
    end
    rr_ptr_d = rr_ptr_q;
    if (|instr_retire_o) rr_ptr_d = (rr_ptr_q == PTR_W'(N - 1)) ? '0 : rr_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
      for (int unsigned c = 0; c < N; c++) latch_q[c] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int unsigned c = 0; c < N; c++) latch_q[c] <= latch_d[c];
    end
  end

`ifdef ICON_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WATCHDOG_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_q [N];
  logic [WD_W-1:0] wd_cnt_d [N];

  // A drop pops the head but is not a retire, so rr_ptr is left alone.
  always_comb begin
    timeout_o = '0;
    for (int unsigned c = 0; c < N; c++) begin
      timeout_o[c] = head_valid[c] & ~instr_retire_o[c] &
                     (wd_cnt_q[c] == WD_W'(WATCHDOG_CYCLES));
      wd_cnt_d[c]  = pop[c] ? '0 : (head_valid[c] ? wd_cnt_q[c] + WD_W'(1) : wd_cnt_q[c]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned c = 0; c < N; c++) wd_cnt_q[c] <= '0;
    end else begin
      for (int unsigned c = 0; c < N; c++) wd_cnt_q[c] <= wd_cnt_d[c];
    end
  end
`else
  assign timeout_o = '0;
`endif

endmodule

// File: doc/back_icon_rr_controller.md
BACK_ICON_RR_CONTROLLER -- requirements
Module: back_icon_rr_controller

Interface
REQ-001 SHALL have parameter NUM_ICON_CHANNELS, default 4, number of interconnect channels (2..8).
REQ-002 SHALL have parameter LOG2_QUEUE_LENGTH, default 4, per-channel instruction queue depth of 2**LOG2_QUEUE_LENGTH.
REQ-003 SHALL have parameter WATCHDOG_CYCLES, default 255, stall limit in cycles (used only under the watchdog macro).
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port icon_instr_dispatch_i, input, type_icon_instr [N], per-channel dispatched instruction.
REQ-007 SHALL have port icon_instr_dispatch_valid_i, input, 1 [N], dispatch valid.
REQ-008 SHALL have port icon_instr_dispatch_ready_o, output, 1 [N], queue not full.
REQ-009 SHALL have port src_addrs_o, output, type_exec_unit_addr [N], head source address, 0 when head invalid.
REQ-010 SHALL have port receiver_lists_o, output, type_icon_receivers_list [N], granted receivers this cycle.
REQ-011 SHALL have port channel_active_o, output, 1 [N], head instruction valid.
REQ-012 SHALL have port tx_req_valid_o, output, 1 [N], source buffer free for this channel.
REQ-013 SHALL have port success_lists_i, input, type_icon_receivers_list [N], receivers that accepted data this cycle.
REQ-014 SHALL have port instr_retire_o, output, 1 [N], head completes this cycle.
REQ-015 SHALL have port timeout_o, output, 1 [N], head dropped by watchdog this cycle.

Function
REQ-016 Dispatch SHALL be accepted at a clock edge when valid and ready; ready SHALL equal not-full, with no bypass when a pop coincides with full.
REQ-017 A pushed instruction SHALL appear at the head no earlier than the cycle after the push.
REQ-018 Priority order SHALL be rr_ptr, rr_ptr+1, ... mod N; rr_ptr SHALL increment mod N on each edge where any channel retires, else hold.
REQ-019 tx_req_valid_o[c] SHALL be 0 iff a higher-priority channel with a valid head has an equal src_addr.euidx; invalid channels SHALL never block.
REQ-020 receiver_lists_o[c] SHALL be head.receiver_list AND NOT success_latched[c] AND NOT (union of grants to higher-priority channels); it SHALL be 0 when the head is invalid or tx_req_valid_o[c] is 0.
REQ-021 success_latched[c] SHALL OR in (success_lists_i[c] AND receiver_lists_o[c]) each edge and SHALL clear to 0 on the retire edge.
REQ-022 instr_retire_o[c] SHALL assert combinationally when the head is valid and (success_latched OR masked success_lists_i) covers every bit of head.receiver_list, including non-EU receivers; the queue SHALL pop on that edge.
REQ-023 A valid head with an all-zero receiver_list SHALL retire in its first valid cycle.
REQ-024 Simultaneous retires on several channels SHALL all pop on the same edge, and rr_ptr SHALL advance by exactly one.

Reset
REQ-025 On reset assertion, queues SHALL empty, rr_ptr SHALL be 0, latches and watchdog counters SHALL be 0, and all outputs SHALL be 0 except icon_instr_dispatch_ready_o, which SHALL be 1; reset mid-transfer SHALL discard in-flight state.

Configuration
REQ-026 Macro ICON_WATCHDOG_EN defined: a per-channel counter SHALL count cycles with a valid, non-retiring head and clear on pop.
REQ-027 ICON_WATCHDOG_EN defined: when the counter reaches WATCHDOG_CYCLES, timeout_o[c] SHALL pulse for one cycle, the head SHALL pop, its latch SHALL clear, and rr_ptr SHALL not advance for that drop.
REQ-028 ICON_WATCHDOG_EN undefined: timeout_o SHALL be tied to 0 and no counter logic SHALL exist.

Structure
REQ-029 type_icon_instr, type_exec_unit_addr and type_icon_receivers_list SHALL come from pkg_dtypes, with no local redefinition.
REQ-030 The per-channel FIFO SHALL be sub-module back_icon_chan_fifo, with async active-high reset, full/empty flags, and head/valid/pop ports.

Verification
REQ-031 N=4; ch0 and ch1 both want receiver bit 2 with rr_ptr=1 -> ch1 granted bit 2, ch0 gets 0 for bit 2.
REQ-032 ch0 and ch2 share euidx 3 with rr_ptr=2 -> tx_req_valid_o[0]=0 and tx_req_valid_o[2]=1; with ch2 invalid -> tx_req_valid_o[0]=1.
REQ-033 receiver_list=0b0110, success 0b0010 then 0b0100 -> retire pulses in the second cycle, latch returns to 0, rr_ptr+1.
REQ-034 Push 16 entries with LOG2_QUEUE_LENGTH=4 -> ready drops after the 16th; pop plus push while full -> 17th not accepted.
REQ-035 ICON_WATCHDOG_EN with WATCHDOG_CYCLES=8 and success never returned -> timeout_o pulses 8 cycles after the head is valid, and the next head appears.
REQ-036 Assert reset mid-transfer with latches nonzero -> all outputs 0 and ready=1 asynchronously.
